lc3b_ifetch: RTL and testbench
==============================

# lc3b_ifetch

Instruction fetch unit for the LC-3b datapath: the producer side of the instruction-register load interface. It owns the fetch PC, issues word reads on the memory read port and buffers returned words with their incremented PC. It presents them to the decode/IR stage through a valid/ready handshake and discards in-flight and buffered words on a control-flow redirect.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_read  out  1  memory read request, held until mem_resp
- mem_address  out  16  byte address of requested word, stable while mem_read=1
- mem_resp  in  1  one-cycle pulse: mem_rdata valid, request complete
- mem_rdata  in  16  returned instruction word
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch address; bit 0 ignored (forced 0)
- inst_valid  out  1  inst/inst_npc hold a valid instruction
- inst_ready  in  1  consumer accepts the instruction this cycle
- inst  out  16  instruction word (lc3b_word)
- inst_npc  out  16  address of inst + 2

## Operation
- fetch_pc register, reset RESET_PC. Each accepted response: fetch_pc <= fetch_pc + 2 (16-bit wrap, 16'hFFFE -> 16'h0000).
- Buffer: DEPTH entries of {inst, npc}, count 0..DEPTH. inst_valid = (count != 0); outputs show the head entry. Pop when inst_valid & inst_ready.
- FSM states IDLE, FETCH, DROP. mem_read = (state != IDLE). mem_address = fetch_pc in FETCH, drop_addr in DROP.
  - IDLE: redirect -> fetch_pc <= redirect_pc, stay IDLE. Else count < DEPTH -> FETCH.
  - FETCH: with no mem_resp, redirect -> drop_addr <= fetch_pc, tgt <= redirect_pc, go DROP. With mem_resp and no redirect: push {mem_rdata, fetch_pc+2}, fetch_pc += 2; stay FETCH if count after this cycle's push/pop < DEPTH, else IDLE. With mem_resp and redirect: discard data, fetch_pc <= redirect_pc, go IDLE.
  - DROP: hold request until mem_resp; discard data, fetch_pc <= tgt, go IDLE. redirect in DROP overwrites tgt (last redirect wins, including same cycle as mem_resp).
- redirect always empties the buffer (count <= 0), in any state. A pop in the redirect cycle still counts as accepted.
- Fetch is issued only with count < DEPTH, and count cannot rise while a request is outstanding, so a push never hits a full buffer. Simultaneous push and pop leaves count unchanged.
- A memory request is never withdrawn once mem_read is high.

## Timing
- Reset values: state IDLE, mem_read 0, mem_address RESET_PC, inst_valid 0, inst 16'h0000, inst_npc 16'h0000, count 0.
- Reset asserted mid-request drops the request immediately: mem_read 0 asynchronously.
- First edge after reset release: IDLE -> FETCH. mem_read is high from that edge.
- mem_resp at edge N: inst_valid high after edge N. Minimum address-to-valid time is one cycle plus memory latency.
- With space remaining, the next request's address appears the cycle after mem_resp, with no idle cycle.
- redirect at edge N: inst_valid low after edge N. The new target's request starts at edge N+1 from IDLE, or one edge after the drained response from DROP.

## Configuration
- LC3B_IFETCH_PREFETCH_EN defined: DEPTH = 2, so fetch runs one instruction ahead of the consumer.
- Not defined: DEPTH = 1. Fetch only issues when the buffer is empty, and FETCH always returns to IDLE after a response.
- Handshake and redirect rules are identical in both builds.

## Structure
- lc3b_types package: lc3b_word (used for inst, inst_npc, mem_address, mem_rdata) and lc3b_ifetch_state enum {IDLE, FETCH, DROP}.
- One sub-module, lc3b_ifetch_buf: DEPTH-entry synchronous FIFO of {lc3b_word inst, lc3b_word npc}, with push, pop, flush, count and head outputs. Flush has priority over push.
- FSM and fetch_pc live in the top module.

## Test plan
- Reset then one fetch: mem_resp with 16'h1234 one cycle after mem_read -> mem_address 16'h0000; inst 16'h1234, inst_npc 16'h0002 valid the next cycle.
- Consumer stalled (inst_ready 0) with prefetch: two responses 16'hAAAA and 16'hBBBB -> count 2, mem_read stays 0. Two pops return AAAA then BBBB with npc 0002 and 0004. Without the macro, only one request is issued.
- redirect to 16'h3000 during an outstanding request at 16'h0004 -> mem_address stays 0004 until mem_resp, data dropped. Next mem_address 3000, then inst_npc 16'h3002.
- redirect to 16'h4000 in the same cycle as mem_resp -> response discarded, inst_valid 0, next request at 16'h4000.
- Wrap: redirect_pc 16'hFFFE, response 16'h0F00 -> inst_npc 16'h0000, next request address 16'h0000.
- Reset asserted mid-FETCH -> mem_read drops immediately, inst_valid 0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/lc3b_ifetch_pkg.sv
// LC-3b shared types for the instruction fetch slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build option LC3B_IFETCH_PREFETCH_EN selects a 2-deep fetch buffer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } lc3b_ifetch_state;

  // One buffered instruction together with its incremented PC.
  typedef struct packed {
    lc3b_word inst;
    lc3b_word npc;
  } lc3b_ifetch_ent;

`ifdef LC3B_IFETCH_PREFETCH_EN
  localparam int IFETCH_DEPTH = 2;
`else
  localparam int IFETCH_DEPTH = 1;
`endif

  localparam int IFETCH_CNT_W = $clog2(IFETCH_DEPTH + 1);

endpackage

// File: rtl/lc3b_ifetch_buf.sv
// Instruction buffer: DEPTH-entry FIFO of {inst, npc}; head entry always at slot 0.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; caller never pushes when full. Flush beats push.
// Ports: clk, reset (async high), push/wdata, pop, flush, count, head.
module lc3b_ifetch_buf
  import lc3b_types::*;
#(
  parameter int DEPTH = IFETCH_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  lc3b_ifetch_ent wdata,
  input  logic           pop,
  input  logic           flush,
  output logic [CW-1:0]  count,
  output lc3b_ifetch_ent head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lc3b_ifetch_ent mem [DEPTH];
  logic           do_pop;
  logic [AW-1:0]  wr_idx;

  assign do_pop = pop && (count != '0);
  // Slot for the new entry after this cycle's shift (if any).
  assign wr_idx = AW'(count - CW'(do_pop));
  assign head   = mem[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      // Listed after the shift so a push into slot 0 wins over the shift.
      if (push) mem[wr_idx] <= wdata;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/lc3b_ifetch.sv
// LC-3b fetch unit: owns fetch PC, issues word reads, buffers {inst, npc} for decode.
// Latency: response at edge N gives inst_valid after edge N; next address the cycle after.
// Backpressure: fetch issues only with buffer space; redirect flushes buffer and drains in-flight read.
// Ports: clk, reset, mem_read/mem_address/mem_resp/mem_rdata, redirect/redirect_pc,
//   inst_valid/inst_ready/inst/inst_npc. Macro LC3B_IFETCH_PREFETCH_EN: buffer depth 2 (else 1).
module lc3b_ifetch
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output logic     mem_read,
  output lc3b_word mem_address,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output logic     inst_valid,
  input  logic     inst_ready,
  output lc3b_word inst,
  output lc3b_word inst_npc
);

  lc3b_ifetch_state        state;
  lc3b_word                fetch_pc;
  lc3b_word                drop_addr;
  lc3b_word                tgt;
  lc3b_word                redir_aligned;
  logic [IFETCH_CNT_W-1:0] count;
  logic [IFETCH_CNT_W:0]   cnt_after;
  logic                    has_space;
  logic                    space_after;
  logic                    push;
  logic                    pop;
  lc3b_ifetch_ent          wdata;
  lc3b_ifetch_ent          head;

  assign redir_aligned = {redirect_pc[15:1], 1'b0};

  assign mem_read    = (state != IDLE);
  assign mem_address = (state == DROP) ? drop_addr : fetch_pc;

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_npc   = head.npc;

  assign pop        = inst_valid && inst_ready;
  assign push       = (state == FETCH) && mem_resp && !redirect;
  assign wdata.inst = mem_rdata;
  assign wdata.npc  = fetch_pc + 16'd2;

  assign has_space = count < IFETCH_CNT_W'(IFETCH_DEPTH);
  // Occupancy after a push plus any simultaneous pop decides whether to keep fetching.
  assign cnt_after   = {1'b0, count} + (IFETCH_CNT_W+1)'(1) - (IFETCH_CNT_W+1)'(pop);
  assign space_after = cnt_after < (IFETCH_CNT_W+1)'(IFETCH_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
      tgt       <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) fetch_pc <= redir_aligned;
          else if (has_space) state <= FETCH;
        end
        FETCH: begin
          if (mem_resp) begin
            if (redirect) begin
              fetch_pc <= redir_aligned;
              state    <= IDLE;
            end else begin
              fetch_pc <= fetch_pc + 16'd2;
              state    <= space_after ? FETCH : IDLE;
            end
          end else if (redirect) begin
            // The read cannot be withdrawn: keep its address and drain it.
            drop_addr <= fetch_pc;
            tgt       <= redir_aligned;
            state     <= DROP;
          end
        end
        DROP: begin
          if (mem_resp) begin
            fetch_pc <= redirect ? redir_aligned : tgt;
            state    <= IDLE;
          end else if (redirect) begin
            tgt <= redir_aligned;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lc3b_ifetch_buf #(
    .DEPTH (IFETCH_DEPTH),
    .CW    (IFETCH_CNT_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_lc3b_ifetch.sv
// Bench for lc3b_ifetch: directed scenarios with literal expectations, then random
// memory latency / consumer stalls / redirects checked every cycle against a queue model.
module tb_lc3b_ifetch;

`ifdef LC3B_IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [15:0] TB_RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_npc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lc3b_ifetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_npc    (inst_npc)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: a read is outstanding; m_dropping: that read belongs to a flushed stream.
  logic        m_busy = 1'b0;
  logic        m_dropping = 1'b0;
  logic [15:0] m_next = TB_RESET_PC;
  logic [15:0] m_drop_addr = 16'h0000;
  logic [15:0] m_tgt = 16'h0000;
  logic [31:0] q[$];

  always @(posedge clk or posedge reset) begin
    logic        pop;
    logic [15:0] rpc;
    if (reset) begin
      m_busy     = 1'b0;
      m_dropping = 1'b0;
      m_next     = TB_RESET_PC;
      q.delete();
    end else begin
      pop = (q.size() != 0) && inst_ready;
      rpc = {redirect_pc[15:1], 1'b0};
      if (m_busy && mem_resp) begin
        if (m_dropping) begin
          m_next     = redirect ? rpc : m_tgt;
          m_dropping = 1'b0;
          m_busy     = 1'b0;
          q.delete();
        end else if (redirect) begin
          q.delete();
          m_next = rpc;
          m_busy = 1'b0;
        end else begin
          if (pop) void'(q.pop_front());
          q.push_back({mem_rdata, m_next + 16'd2});
          m_next = m_next + 16'd2;
          m_busy = (q.size() < DEPTH);
        end
      end else if (m_busy) begin
        if (redirect) begin
          q.delete();
          if (!m_dropping) begin
            m_dropping  = 1'b1;
            m_drop_addr = m_next;
          end
          m_tgt = rpc;
        end else if (pop) begin
          void'(q.pop_front());
        end
      end else begin
        if (redirect) begin
          q.delete();
          m_next = rpc;
        end else begin
          m_busy = (q.size() < DEPTH);
          if (pop) void'(q.pop_front());
        end
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [31:0] h;
    chk("mem_read", mem_read, m_busy);
    if (m_busy) chk("mem_address", mem_address, m_dropping ? m_drop_addr : m_next);
    chk("inst_valid", inst_valid, q.size() != 0);
    chk("occupancy", q.size() <= DEPTH, 1'b1);
    if (q.size() != 0) begin
      h = q[0];
      chk("inst", inst, h[31:16]);
      chk("inst_npc", inst_npc, h[15:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (mem_read) break;
      tick();
    end
    chk("wait_req", mem_read, 1'b1);
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (3) tick();
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_address", mem_address, TB_RESET_PC);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_npc", inst_npc, 16'h0000);
    reset = 1'b0;
    tick();
    chk("first_read", mem_read, 1'b1);
    chk("first_addr", mem_address, 16'h0000);

    // Single fetch, consumer stalled
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_resp = 1'b0;
    chk("f1_valid", inst_valid, 1'b1);
    chk("f1_inst", inst, 16'h1234);
    chk("f1_npc", inst_npc, 16'h0002);
    chk("f1_prefetch", mem_read, DEPTH == 2);
    if (DEPTH == 2) begin
      mem_resp = 1'b1; mem_rdata = 16'h5678;
    end
    tick();
    mem_resp = 1'b0;
    chk("full_no_read", mem_read, 1'b0);
    chk("full_head", inst, 16'h1234);
    inst_ready = 1'b1;
    tick();
    chk("pop1_valid", inst_valid, DEPTH == 2);
    wait_req();
    chk("req_addr", mem_address, (DEPTH == 2) ? 16'h0004 : 16'h0002);

    // Redirect with an outstanding read
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h3000;
    tick();
    redirect = 1'b0;
    chk("drop_read", mem_read, 1'b1);
    chk("drop_addr", mem_address, (DEPTH == 2) ? 16'h0004 : 16'h0002);
    chk("drop_valid", inst_valid, 1'b0);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_resp = 1'b0;
    chk("drained_read", mem_read, 1'b0);
    chk("drained_valid", inst_valid, 1'b0);
    tick();
    chk("tgt_addr", mem_address, 16'h3000);
    mem_resp = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_resp = 1'b0;
    chk("tgt_inst", inst, 16'h1111);
    chk("tgt_npc", inst_npc, 16'h3002);

    // Redirect in the same cycle as a response
    inst_ready = 1'b1;
    wait_req();
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    redirect = 1'b1; redirect_pc = 16'h4000;
    tick();
    mem_resp = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    chk("same_valid", inst_valid, 1'b0);
    chk("same_read", mem_read, 1'b0);
    tick();
    chk("same_addr", mem_address, 16'h4000);

    // Wrap at top of memory; odd target bit ignored
    mem_resp = 1'b1; mem_rdata = 16'h2222;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    mem_resp = 1'b0; redirect = 1'b0;
    tick();
    chk("wrap_addr", mem_address, 16'hFFFE);
    mem_resp = 1'b1; mem_rdata = 16'h0F00;
    tick();
    mem_resp = 1'b0;
    chk("wrap_inst", inst, 16'h0F00);
    chk("wrap_npc", inst_npc, 16'h0000);
    inst_ready = 1'b1;
    wait_req();
    chk("wrap_next", mem_address, 16'h0000);

    // Reset in the middle of a request
    inst_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_read", mem_read, 1'b0);
    chk("arst_valid", inst_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_restart_read", mem_read, 1'b1);
    chk("rst_restart_addr", mem_address, TB_RESET_PC);

    // Random traffic against the model
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1500 == 1499) begin
        mem_resp = 1'b0; redirect = 1'b0;
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      mem_resp    = 1'b0;
      if (mem_read) begin
        if (lat == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = 16'($urandom);
          lat       = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      tick();
    end
    mem_resp = 1'b0; redirect = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
